// File: rtl/cpu_pkg.sv
// Shared minisys CPU constants and register-file state type.
package cpu_pkg;

  localparam int REG_ZERO        = 0;
  localparam int REG_DBG_DEFAULT = 4;
  localparam int REG_RA          = 31;
  localparam int DATA_W_DEFAULT  = 32;

  typedef enum logic {
    GPR_CLEAR,
    GPR_RUN
  } gpr_state_t;

endpackage

// File: rtl/gpr_file_mp_rd_mux.sv
// Read-select for one register-file port.
// Applies clear masking, the hard-wired zero entry and write bypass.
module gpr_rd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_entry,
  output logic [DATA_W-1:0] o_data
);

  logic w_zero;
  logic w_byp;

  assign w_zero = (ZERO_REG != 0) &&
                  (i_idx == ADDR_W'(REG_ZERO));
  assign w_byp  = (BYPASS != 0) && i_we &&
                  (i_waddr == i_idx);

  // Zero wins over bypass so a discarded r0 write never shows.
  always_comb begin
    o_data = i_entry;
    if (i_clear || w_zero)
      o_data = '0;
    else if (w_byp)
      o_data = i_wdata;
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Parametrised GPR file: 2 comb read ports, 1 write port,
// sweep-clear FSM and registered debug probe.
module gpr_file_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int ADDR_W      = 5,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  parameter int DBG_RST_SEL = REG_DBG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              dbg_sel_en,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  gpr_state_t        r_state;
  gpr_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dbg;
  logic [DATA_W-1:0] w_dbg;
  logic [ADDR_W-1:0] w_dbg_sel;
  logic              w_clear;
  logic              w_wr;

  assign w_clear = (r_state == GPR_CLEAR);
  assign ready   = ~w_clear;
  assign w_wr    = we && !w_clear &&
                   !((ZERO_REG != 0) &&
                     (waddr == ADDR_W'(REG_ZERO)));
  assign w_dbg_sel = dbg_sel_en ? dbg_sel
                                : ADDR_W'(DBG_RST_SEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GPR_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      GPR_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_MAX)
          w_state_nxt = GPR_RUN;
      end
      GPR_RUN: begin
        if (clr) begin
          w_state_nxt = GPR_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  // No reset on the array so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (w_clear)
      r_mem[r_cnt] <= '0;
    else if (w_wr)
      r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dbg <= '0;
    else if (!w_clear)
      r_dbg <= w_dbg;
  end

  assign dbg_data = r_dbg;

  gpr_rd_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd_a (
    .i_clear(w_clear), .i_idx(ra),
    .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_entry(r_mem[ra]),
    .o_data(rdata_a)
  );

  gpr_rd_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd_b (
    .i_clear(w_clear), .i_idx(rb),
    .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_entry(r_mem[rb]),
    .o_data(rdata_b)
  );

  gpr_rd_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd_dbg (
    .i_clear(w_clear), .i_idx(w_dbg_sel),
    .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_entry(r_mem[w_dbg_sel]),
    .o_data(w_dbg)
  );

endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: default, no-bypass/no-zero and
// 8x16 instances checked against a per-cycle reference model.
module tb_gpr_file_mp;

  logic clk = 1'b0;
  logic rst_n;

  logic        clr, we, dsel_en;
  logic [4:0]  waddr, ra, rb, dsel;
  logic [31:0] wdata;

  logic        clr_c, we_c, dsel_en_c;
  logic [2:0]  waddr_c, ra_c, rb_c, dsel_c;
  logic [15:0] wdata_c;

  logic        ready_a, ready_b, ready_c;
  logic [31:0] rda_a, rdb_a, dbg_a;
  logic [31:0] rda_b, rdb_b, dbg_b;
  logic [15:0] rda_c, rdb_c, dbg_c;

  int checks = 0;
  int errors = 0;

  int          left [3];
  logic [31:0] mdbg [3];
  logic [31:0] mem  [3][32];
  int          iwe [3], iwa [3], ira [3];
  int          irb [3], isel [3], iclr [3];
  logic [31:0] iwd [3];

  always #5 clk = ~clk;

  gpr_file_mp u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .ready(ready_a), .we(we), .waddr(waddr),
    .wdata(wdata), .ra(ra), .rb(rb),
    .rdata_a(rda_a), .rdata_b(rdb_a),
    .dbg_sel_en(dsel_en), .dbg_sel(dsel),
    .dbg_data(dbg_a)
  );

  gpr_file_mp #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .ready(ready_b), .we(we), .waddr(waddr),
    .wdata(wdata), .ra(ra), .rb(rb),
    .rdata_a(rda_b), .rdata_b(rdb_b),
    .dbg_sel_en(dsel_en), .dbg_sel(dsel),
    .dbg_data(dbg_b)
  );

  gpr_file_mp #(.DATA_W(16), .ADDR_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr_c),
    .ready(ready_c), .we(we_c), .waddr(waddr_c),
    .wdata(wdata_c), .ra(ra_c), .rb(rb_c),
    .rdata_a(rda_c), .rdata_b(rdb_c),
    .dbg_sel_en(dsel_en_c), .dbg_sel(dsel_c),
    .dbg_data(dbg_c)
  );

  function automatic int zr(int k);
    return (k != 1) ? 1 : 0;
  endfunction

  function automatic int depth(int k);
    return (k == 2) ? 8 : 32;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Expected read value of instance k at index idx.
  function automatic logic [31:0] rd(int k, int idx);
    if (left[k] != 0) return 32'd0;
    if (zr(k) != 0 && idx == 0) return 32'd0;
    if (zr(k) == 1 && iwe[k] != 0 && iwa[k] == idx)
      return iwd[k];
    return mem[k][idx];
  endfunction

  task automatic model_rst();
    for (int k = 0; k < 3; k++) begin
      left[k] = depth(k);
      mdbg[k] = 32'd0;
    end
  endtask

  task automatic cap();
    for (int k = 0; k < 2; k++) begin
      iwe[k]  = int'(we);
      iwa[k]  = int'(waddr);
      iwd[k]  = wdata;
      ira[k]  = int'(ra);
      irb[k]  = int'(rb);
      iclr[k] = int'(clr);
      isel[k] = dsel_en ? int'(dsel) : 4;
    end
    iwe[2]  = int'(we_c);
    iwa[2]  = int'(waddr_c);
    iwd[2]  = {16'd0, wdata_c};
    ira[2]  = int'(ra_c);
    irb[2]  = int'(rb_c);
    iclr[2] = int'(clr_c);
    isel[2] = dsel_en_c ? int'(dsel_c) : 4;
  endtask

  task automatic model_edge();
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      if (left[k] > 0) begin
        left[k]--;
        if (left[k] == 0)
          for (int i = 0; i < depth(k); i++)
            mem[k][i] = 32'd0;
      end else begin
        d = rd(k, isel[k]);
        mdbg[k] = d;
        if (iwe[k] != 0 && !(zr(k) != 0 && iwa[k] == 0))
          mem[k][iwa[k]] = iwd[k];
        if (iclr[k] != 0) left[k] = depth(k);
      end
    end
  endtask

  // Check every output against the model, then advance one edge.
  task automatic cyc();
    cap();
    if (!rst_n) model_rst();
    #3;
    chk("ready_a", {31'd0, ready_a}, {31'd0, left[0] == 0});
    chk("ready_b", {31'd0, ready_b}, {31'd0, left[1] == 0});
    chk("ready_c", {31'd0, ready_c}, {31'd0, left[2] == 0});
    chk("rda_a", rda_a, rd(0, ira[0]));
    chk("rdb_a", rdb_a, rd(0, irb[0]));
    chk("dbg_a", dbg_a, mdbg[0]);
    chk("rda_b", rda_b, rd(1, ira[1]));
    chk("rdb_b", rdb_b, rd(1, irb[1]));
    chk("dbg_b", dbg_b, mdbg[1]);
    chk("rda_c", {16'd0, rda_c}, rd(2, ira[2]));
    chk("rdb_c", {16'd0, rdb_c}, rd(2, irb[2]));
    chk("dbg_c", {16'd0, dbg_c}, mdbg[2]);
    @(posedge clk);
    if (!rst_n) model_rst();
    else model_edge();
    #1;
  endtask

  task automatic wait_rdy(output int n, output int nc);
    n = 0;
    nc = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      if (ready_c !== 1'b1) nc++;
      cyc();
      n++;
    end
  endtask

  int n, nc;

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) mem[k][i] = 32'd0;
    model_rst();
    rst_n = 1'b0;
    clr = 0; we = 1; waddr = 5'd7; wdata = '1;
    ra = 5'd7; rb = 5'd0; dsel_en = 0; dsel = 0;
    clr_c = 0; we_c = 1; waddr_c = 3'd3;
    wdata_c = 16'hFFFF; ra_c = 3'd3; rb_c = 0;
    dsel_en_c = 0; dsel_c = 0;
    #1;
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_rdy(n, nc);
    chk("sweep_len", n, 32);
    chk("sweep_len_c", nc, 8);
    we = 0;
    #1;
    chk("no_sweep_write", rda_a, 32'd0);

    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; ra = 5'd5;
    #1;
    chk("bypass_a", rda_a, 32'hDEADBEEF);
    chk("nobypass_b", rda_b, 32'd0);
    cyc();
    we = 0;
    #1;
    chk("persist_a", rda_a, 32'hDEADBEEF);
    chk("persist_b", rda_b, 32'hDEADBEEF);
    cyc();

    we = 1; waddr = 5'd0; wdata = 32'h12345678;
    cyc();
    we = 0; ra = 0; rb = 0;
    #1;
    chk("zero_ra_a", rda_a, 32'd0);
    chk("zero_rb_a", rdb_a, 32'd0);
    chk("nozero_ra_b", rda_b, 32'h12345678);
    chk("nozero_rb_b", rdb_b, 32'h12345678);
    cyc();

    dsel_en = 0; we = 1; waddr = 5'd4; wdata = 32'h7;
    cyc();
    chk("dbg_dflt_a", dbg_a, 32'h7);
    we = 0;
    cyc();
    chk("dbg_dflt_b", dbg_b, 32'h7);
    dsel_en = 1; dsel = 5'd5;
    cyc();
    chk("dbg_sel_a", dbg_a, 32'hDEADBEEF);

    clr = 1;
    cyc();
    clr = 0;
    chk("clr_ready", {31'd0, ready_a}, 32'd0);
    repeat (10) cyc();
    clr = 1;
    cyc();
    clr = 0;
    wait_rdy(n, nc);
    chk("clr_ignored", n + 11, 32);

    we = 1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
    cyc();
    we = 0; ra = 5'd9;
    #1;
    chk("r9_written", rda_a, 32'hA5A5A5A5);
    clr = 1;
    cyc();
    clr = 0;
    repeat (20) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    wait_rdy(n, nc);
    chk("rst_sweep_len", n, 32);
    chk("rst_sweep_len_c", nc, 8);
    chk("r9_cleared", rda_a, 32'd0);

    for (int i = 0; i < 1000; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      we = 1'($urandom);
      waddr = 5'($urandom);
      wdata = $urandom;
      ra = 5'($urandom);
      rb = 5'($urandom);
      dsel_en = 1'($urandom);
      dsel = 5'($urandom);
      clr_c = ($urandom_range(0, 49) == 0);
      we_c = 1'($urandom);
      waddr_c = 3'($urandom);
      wdata_c = 16'($urandom);
      ra_c = 3'($urandom);
      rb_c = 3'($urandom);
      dsel_en_c = 1'($urandom);
      dsel_c = 3'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
